// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral with a read/write register bank.
// Frame: R/W bit (1=write), ADDR_W address bits, DATA_W data bits, all MSB first.
// All SPI pins are synchronised into clk; edges come from the last two flops of each chain.
module spi_regfile_peripheral #(
   parameter int unsigned NUM_REGS    = 5,
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sclk,
   input  logic                         COPI,
   input  logic                         cs,
   output logic                         CIPO,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q,
   output logic                         wr_strobe,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic                         frame_err
);

   localparam int unsigned FRAME_BITS = 1 + ADDR_W + DATA_W;
   localparam int unsigned CntW       = $clog2(FRAME_BITS + 2);
   localparam logic [CntW-1:0]   CntCmd   = CntW'(1 + ADDR_W);
   localparam logic [CntW-1:0]   CntFrame = CntW'(FRAME_BITS);
   localparam logic [CntW-1:0]   CntOver  = CntW'(FRAME_BITS + 1);
   localparam logic [ADDR_W:0]   NumRegsL = (ADDR_W + 1)'(NUM_REGS);

   typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

   state_e                      state_q, state_d;
   // One extra flop beyond the synchroniser holds the previous value for edge detection
   logic [SYNC_STAGES:0]        sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES:0]        cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0]      copi_sync_q, copi_sync_d;
   logic [CntW-1:0]             bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0]       shift_q, shift_d;
   logic                        rw_q, rw_d;
   logic [ADDR_W-1:0]           addr_q, addr_d;
   logic                        cmd_done_q, cmd_done_d;
   logic [DATA_W-1:0]           out_q, out_d;
   logic                        cipo_q, cipo_d;
   logic [NUM_REGS*DATA_W-1:0]  regs_q, regs_d;
   logic [ADDR_W-1:0]           wr_addr_q, wr_addr_d;

   logic                        sclk_rise, sclk_fall, cs_rise, cs_fall, copi_s;
   logic [FRAME_BITS-1:0]       shift_next;
   logic [DATA_W-1:0]           rd_data;
   logic                        cnt_full, addr_ok, commit_wr, commit_err;

   // Synchroniser chains and edge detection
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-1:0], sclk};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-1:0], cs};
      copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], COPI};
      sclk_rise   = sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES];
      sclk_fall   = ~sclk_sync_q[SYNC_STAGES-1] & sclk_sync_q[SYNC_STAGES];
      cs_rise     = cs_sync_q[SYNC_STAGES-1] & ~cs_sync_q[SYNC_STAGES];
      cs_fall     = ~cs_sync_q[SYNC_STAGES-1] & cs_sync_q[SYNC_STAGES];
      copi_s      = copi_sync_q[SYNC_STAGES-1];
   end

   // Commit decision, valid while in StCommit
   always_comb begin
      cnt_full   = (bit_cnt_q == CntFrame);
      addr_ok    = ({1'b0, addr_q} < NumRegsL);
      commit_wr  = (state_q == StCommit) && cnt_full && rw_q && addr_ok;
      commit_err = (state_q == StCommit) &&
                   (((bit_cnt_q != '0) && !cnt_full) || (cnt_full && rw_q && !addr_ok));
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic; a cs rise takes priority over any sclk edge
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (cs_fall) state_d = StShift;
         StShift:  if (cs_rise) state_d = StCommit;
         StCommit: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      wr_strobe = commit_wr;
      frame_err = commit_err;
   end

   // Read mux on the address being latched; out-of-range addresses read as zero
   always_comb begin
      shift_next = {shift_q[FRAME_BITS-2:0], copi_s};
      rd_data    = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (shift_next[ADDR_W-1:0] == ADDR_W'(i)) rd_data = regs_q[i*DATA_W +: DATA_W];
      end
   end

   // Datapath next-state: shifting, command latch, read-out and register commit
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rw_d       = rw_q;
      addr_d     = addr_q;
      cmd_done_d = cmd_done_q;
      out_d      = out_q;
      cipo_d     = cipo_q;
      regs_d     = regs_q;
      wr_addr_d  = wr_addr_q;
      unique case (state_q)
         StIdle: begin
            bit_cnt_d = '0;
            cipo_d    = 1'b0;
            if (cs_fall) begin
               shift_d    = '0;
               rw_d       = 1'b0;
               addr_d     = '0;
               cmd_done_d = 1'b0;
               out_d      = '0;
            end
         end
         StShift: begin
            if (cs_rise) begin
               // sclk edge in the same cycle is dropped
            end else if (cs_fall) begin
               shift_d    = '0;
               bit_cnt_d  = '0;
               rw_d       = 1'b0;
               addr_d     = '0;
               cmd_done_d = 1'b0;
               out_d      = '0;
               cipo_d     = 1'b0;
            end else if (sclk_rise) begin
               shift_d = shift_next;
               if (bit_cnt_q != CntOver) bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == CntCmd - 1'b1) begin
                  rw_d       = shift_next[ADDR_W];
                  addr_d     = shift_next[ADDR_W-1:0];
                  cmd_done_d = 1'b1;
                  out_d      = shift_next[ADDR_W] ? '0 : rd_data;
               end
            end else if (sclk_fall && cmd_done_q && !rw_q) begin
               cipo_d = out_q[DATA_W-1];
               out_d  = out_q << 1;
            end
         end
         StCommit: begin
            bit_cnt_d = '0;
            cipo_d    = 1'b0;
            if (commit_wr) begin
               wr_addr_d = addr_q;
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (addr_q == ADDR_W'(i)) regs_d[i*DATA_W +: DATA_W] = shift_q[DATA_W-1:0];
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath and synchroniser registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         copi_sync_q <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         cmd_done_q  <= 1'b0;
         out_q       <= '0;
         cipo_q      <= 1'b0;
         regs_q      <= '0;
         wr_addr_q   <= '0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         copi_sync_q <= copi_sync_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         cmd_done_q  <= cmd_done_d;
         out_q       <= out_d;
         cipo_q      <= cipo_d;
         regs_q      <= regs_d;
         wr_addr_q   <= wr_addr_d;
      end
   end

   assign CIPO    = cipo_q;
   assign reg_q   = regs_q;
   assign wr_addr = wr_addr_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral: default-size instance plus a 16x16 instance.
module tb_spi_regfile_peripheral;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         sclk = 1'b0;
   logic         copi = 1'b0;
   logic         cs1 = 1'b1;
   logic         cs2 = 1'b1;
   logic         cipo1, cipo2;
   logic [39:0]  reg_q1;
   logic [255:0] reg_q2;
   logic         strb1, strb2, err1, err2;
   logic [6:0]   wa1, wa2;

   int n_asserts = 0;
   int n_fail = 0;
   int strb1_cnt = 0, err1_cnt = 0, strb2_cnt = 0, err2_cnt = 0;
   int s_strb, s_err;
   logic [31:0] rx;

   always #5 clk = ~clk;

   spi_regfile_peripheral dut1 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .COPI(copi), .cs(cs1), .CIPO(cipo1),
      .reg_q(reg_q1), .wr_strobe(strb1), .wr_addr(wa1), .frame_err(err1)
   );

   spi_regfile_peripheral #(.NUM_REGS(16), .DATA_W(16)) dut2 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .COPI(copi), .cs(cs2), .CIPO(cipo2),
      .reg_q(reg_q2), .wr_strobe(strb2), .wr_addr(wa2), .frame_err(err2)
   );

   // Pulse counters, sampled away from the active edge
   always @(negedge clk) begin
      if (strb1) strb1_cnt++;
      if (err1)  err1_cnt++;
      if (strb2) strb2_cnt++;
      if (err2)  err2_cnt++;
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full frame: cs low, nbits clocked MSB first, CIPO sampled just before each rise, cs high
   task automatic spi_frame(input logic [31:0] data, input int nbits, input bit sel2,
                            output logic [31:0] rxd);
      rxd = '0;
      if (sel2) cs2 = 1'b0; else cs1 = 1'b0;
      #80;
      for (int i = nbits - 1; i >= 0; i--) begin
         copi = data[i];
         #80;
         rxd = {rxd[30:0], (sel2 ? cipo2 : cipo1)};
         sclk = 1'b1;
         #80;
         sclk = 1'b0;
      end
      #80;
      cs1 = 1'b1;
      cs2 = 1'b1;
      #200;
   endtask

   initial begin
      logic [15:0] part;
      #23;
      // Reset state
      check("rst_reg_q", reg_q1, 40'h0);
      check("rst_cipo", cipo1, 1'b0);
      check("rst_strobe", strb1, 1'b0);
      check("rst_frame_err", err1, 1'b0);
      check("rst_wr_addr", wa1, 7'h0);
      rst_n = 1'b1;
      #100;

      // 1: write reg 4 = 0xAA
      s_strb = strb1_cnt; s_err = err1_cnt;
      spi_frame(32'h84AA, 16, 1'b0, rx);
      check("t1_strobe_cnt", strb1_cnt - s_strb, 1);
      check("t1_err_cnt", err1_cnt - s_err, 0);
      check("t1_wr_addr", wa1, 7'd4);
      check("t1_reg_q", reg_q1, 40'hAA_00_00_00_00);

      // cs toggle with no sclk: no error
      s_err = err1_cnt;
      cs1 = 1'b0; #200; cs1 = 1'b1; #200;
      check("cs_toggle_err", err1_cnt - s_err, 0);

      // 2: write reg 1 = 0x55, then read it back
      spi_frame(32'h8155, 16, 1'b0, rx);
      check("t2_reg_q_wr", reg_q1, 40'hAA_00_00_55_00);
      check("t2_wr_addr", wa1, 7'd1);
      s_strb = strb1_cnt; s_err = err1_cnt;
      spi_frame(32'h0100, 16, 1'b0, rx);
      check("t2_rd_data", rx[15:0], 16'h0055);
      check("t2_rd_strobe", strb1_cnt - s_strb, 0);
      check("t2_rd_err", err1_cnt - s_err, 0);
      check("t2_reg_q_rd", reg_q1, 40'hAA_00_00_55_00);

      // 3: short 12-bit frame and 17-bit overrun, both aimed at reg 3
      s_strb = strb1_cnt; s_err = err1_cnt;
      spi_frame(32'h83F, 12, 1'b0, rx);
      check("t3_short_err", err1_cnt - s_err, 1);
      check("t3_short_reg_q", reg_q1, 40'hAA_00_00_55_00);
      s_err = err1_cnt;
      spi_frame(32'h107FF, 17, 1'b0, rx);
      check("t3_over_err", err1_cnt - s_err, 1);
      check("t3_over_reg_q", reg_q1, 40'hAA_00_00_55_00);
      check("t3_strobe", strb1_cnt - s_strb, 0);

      // 4: out-of-range write and read at addr 0x10
      s_strb = strb1_cnt; s_err = err1_cnt;
      spi_frame(32'h90CC, 16, 1'b0, rx);
      check("t4_wr_err", err1_cnt - s_err, 1);
      check("t4_wr_strobe", strb1_cnt - s_strb, 0);
      check("t4_reg_q", reg_q1, 40'hAA_00_00_55_00);
      s_err = err1_cnt;
      spi_frame(32'h1000, 16, 1'b0, rx);
      check("t4_rd_data", rx[15:0], 16'h0000);
      check("t4_rd_err", err1_cnt - s_err, 0);

      // 5: reset after 9 bits of 0x82FF, then a clean write of 0x07 to reg 2
      part = 16'h82FF;
      cs1 = 1'b0;
      #80;
      for (int i = 15; i >= 7; i--) begin
         copi = part[i];
         #80; sclk = 1'b1; #80; sclk = 1'b0;
      end
      #40;
      rst_n = 1'b0;
      #50;
      check("t5_rst_reg_q", reg_q1, 40'h0);
      check("t5_rst_wr_addr", wa1, 7'd0);
      rst_n = 1'b1;
      #50;
      cs1 = 1'b1;
      #200;
      s_strb = strb1_cnt; s_err = err1_cnt;
      spi_frame(32'h8207, 16, 1'b0, rx);
      check("t5_reg_q", reg_q1, 40'h00_00_07_00_00);
      check("t5_strobe", strb1_cnt - s_strb, 1);
      check("t5_err", err1_cnt - s_err, 0);
      check("t5_wr_addr", wa1, 7'd2);

      // 6: wide instance, write and read back reg 15
      s_strb = strb2_cnt; s_err = err2_cnt;
      spi_frame(32'h8FBEEF, 24, 1'b1, rx);
      check("t6_strobe", strb2_cnt - s_strb, 1);
      check("t6_wr_addr", wa2, 7'd15);
      check("t6_reg15", reg_q2[255:240], 16'hBEEF);
      check("t6_reg_low", reg_q2[239:0], 240'h0);
      spi_frame(32'h0F0000, 24, 1'b1, rx);
      check("t6_rd_data", rx[23:0], 24'h00BEEF);
      check("t6_err", err2_cnt - s_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
